frame_commit_ctrl: RTL
======================

FRAME_COMMIT_CTRL -- requirements
Module: frame_commit_ctrl

Interface
REQ-001 SHALL have parameter FORCE_COMMIT_CYCLES, default 2_000_000, the maximum number of cycles a pending datagram waits for vblank before a forced commit.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the control core presents a new datagram.
REQ-005 SHALL have port in_data  input  MESSAGE_SIZE  the datagram from the control core.
REQ-006 SHALL have port in_ready  output  1  the controller accepts in_data this cycle.
REQ-007 SHALL have port vblank_start  input  1  one-cycle pulse from the output interface at the start of vertical blanking.
REQ-008 SHALL have port freeze  input  1  while high, all commits are inhibited (game pause).
REQ-009 SHALL have port disp_data  output  MESSAGE_SIZE  registered datagram driving the output interface.
REQ-010 SHALL have port commit_pulse  output  1  one-cycle pulse in the cycle disp_data takes a new value.
REQ-011 SHALL have port drop_count  output  8  saturating count of pending datagrams overwritten before commit.
REQ-012 SHALL have port forced_count  output  8  saturating count of commits caused by timeout.

Function
REQ-013 SHALL implement the FSM states EMPTY (no pending datagram) and PENDING (pend_data holds an uncommitted datagram).
REQ-014 SHALL tie in_ready to 1; a transfer occurs when in_valid=1.
REQ-015 EMPTY: on a transfer with in_data != disp_data, SHALL store pend_data<=in_data, clear wait_cnt and go to PENDING; a transfer with in_data == disp_data SHALL be discarded.
REQ-016 PENDING: on a transfer, SHALL overwrite pend_data (latest wins) and increment drop_count, saturating at 255; wait_cnt SHALL NOT restart.
REQ-017 PENDING, freeze=0, vblank_start=1: SHALL take disp_data from the effective value (in_data if transferred this cycle, else pend_data) at the next clk edge, assert commit_pulse with it and return to EMPTY.
REQ-018 PENDING, freeze=0, no vblank_start, wait_cnt == FORCE_COMMIT_CYCLES-1: SHALL commit as in REQ-017 and increment forced_count, saturating at 255.
REQ-019 wait_cnt SHALL increment each PENDING cycle while freeze=0; it SHALL hold while freeze=1 and clear on entry to PENDING; its width SHALL be $clog2(FORCE_COMMIT_CYCLES).
REQ-020 freeze=1 SHALL suppress commits, including at vblank; transfers SHALL still update pend_data per REQ-015/016.
REQ-021 Commit latency from vblank_start to updated disp_data/commit_pulse SHALL be exactly 1 cycle.
REQ-022 A transfer overwriting pend_data in the same cycle as a commit SHALL increment drop_count.
REQ-023 commit_pulse SHALL never assert on consecutive cycles; it is at most one per PENDING entry.

Reset
REQ-024 rst=1 SHALL force state=EMPTY, disp_data=0, pend_data=0, commit_pulse=0, wait_cnt=0, drop_count=0, forced_count=0, mid-operation included; a pending datagram is lost.
REQ-025 in_ready SHALL read 1 during reset, but transfers during reset SHALL be ignored.

Structure
REQ-026 MESSAGE_SIZE SHALL come from the shared constants package; the FSM state enum SHALL live in the shared typedefs package as commit_state_t.
REQ-027 The saturating 8-bit counter SHALL be one sub-module, sat_counter8, instantiated for drop_count and forced_count.
REQ-028 The top-level SHALL replace its free-running datagram register with this block.

Verification
REQ-029 Reset, then in_data=A (≠0) for one cycle, vblank_start 5 cycles later -> one cycle after vblank: disp_data=A, commit_pulse=1 for 1 cycle.
REQ-030 A, B, C transferred on consecutive cycles, then vblank -> disp_data=C, drop_count=2.
REQ-031 In PENDING with pend_data=A, in_data=B in the same cycle as vblank_start -> disp_data=B, drop_count=1.
REQ-032 FORCE_COMMIT_CYCLES=16, A transferred, no vblank -> commit 16 cycles later; forced_count=1.
REQ-033 freeze=1, A transferred, two vblanks -> no commit; freeze drops before the third vblank -> disp_data=A on it.
REQ-034 rst asserted while PENDING -> all outputs 0; a later vblank -> no commit_pulse; 300 overwrites -> drop_count holds 255.

Source files
------------

// File: rtl/frame_commit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_commit_ctrl_pkg
//  Description : Shared constants and typedefs for the frame commit controller
//                (datagram width and commit FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_commit_ctrl_pkg;

  // Width of one control datagram from the control core.
  localparam int MESSAGE_SIZE = 32;

  // Commit FSM: EMPTY = nothing waiting, PENDING = pend_data awaits a commit.
  typedef enum logic [0:0] {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

endpackage : frame_commit_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter8
//  Description : 8-bit event counter that sticks at 255 instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  // Count one event per cycle, holding at all-ones once saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (inc_i && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter8
`default_nettype wire

// File: rtl/frame_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_commit_ctrl
//  Description : Holds the latest datagram from the control core and commits
//                it to the display interface at vertical blanking, or after a
//                timeout if blanking never arrives. Commits are inhibited while
//                frozen. Counts overwritten datagrams and forced commits.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_commit_ctrl
  import frame_commit_ctrl_pkg::*;
#(
  parameter int unsigned FORCE_COMMIT_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [MESSAGE_SIZE-1:0] in_data,
  output logic                    in_ready,
  input  logic                    vblank_start,
  input  logic                    freeze,
  output logic [MESSAGE_SIZE-1:0] disp_data,
  output logic                    commit_pulse,
  output logic [7:0]              drop_count,
  output logic [7:0]              forced_count
);

  // A single-cycle timeout still needs a one-bit counter to exist.
  localparam int WAIT_W = (FORCE_COMMIT_CYCLES > 1) ? $clog2(FORCE_COMMIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(FORCE_COMMIT_CYCLES - 1);

  commit_state_t             state_q;
  logic [MESSAGE_SIZE-1:0]   pend_data_q;
  logic [MESSAGE_SIZE-1:0]   disp_data_q;
  logic                      commit_pulse_q;
  logic [WAIT_W-1:0]         wait_cnt_q;

  logic                      w_pending;
  logic                      w_vblank_commit;
  logic                      w_force_commit;
  logic                      w_commit;
  logic                      w_drop_inc;
  logic [MESSAGE_SIZE-1:0]   w_eff_data;

  // The controller never back-pressures; transfers during reset are simply
  // ignored because the FSM below is held in reset.
  assign in_ready = 1'b1;

  // Commit decisions: a vblank always wins over the timeout, and freeze
  // blocks both. A same-cycle transfer is what gets committed.
  always_comb begin
    w_pending       = (state_q == ST_PENDING);
    w_vblank_commit = w_pending && !freeze && vblank_start;
    w_force_commit  = w_pending && !freeze && !vblank_start && (wait_cnt_q == c_WAIT_LAST);
    w_commit        = w_vblank_commit || w_force_commit;
    w_drop_inc      = w_pending && in_valid;
    w_eff_data      = in_valid ? in_data : pend_data_q;
  end

  // Commit FSM with registered display data and commit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      pend_data_q    <= '0;
      disp_data_q    <= '0;
      commit_pulse_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      commit_pulse_q <= 1'b0;
      case (state_q)
        ST_EMPTY: begin
          // A datagram identical to what is on screen needs no commit.
          if (in_valid && (in_data != disp_data_q)) begin
            pend_data_q <= in_data;
            wait_cnt_q  <= '0;
            state_q     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          // Latest datagram wins; the timeout keeps running from first entry.
          if (in_valid) begin
            pend_data_q <= in_data;
          end
          if (w_commit) begin
            disp_data_q    <= w_eff_data;
            commit_pulse_q <= 1'b1;
            wait_cnt_q     <= '0;
            state_q        <= ST_EMPTY;
          end else if (!freeze) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  sat_counter8 u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_drop_inc),
    .count_o (drop_count)
  );

  sat_counter8 u_forced_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_force_commit),
    .count_o (forced_count)
  );

  assign disp_data    = disp_data_q;
  assign commit_pulse = commit_pulse_q;

endmodule : frame_commit_ctrl
`default_nettype wire
